bcd_down_counter: RTL and testbench
===================================

// Module: bcd_down_counter
//
// PURPOSE
//  Loadable, cascaded BCD down-counter. It is the count-down counterpart of the
//  decade up-counter. Software or a control FSM loads a BCD value, and the block
//  decrements it once per enabled clock. It flags terminal count with a one-cycle
//  borrow pulse, and then stops or wraps. Typical use is countdown timers and
//  delay generators, next to the decade up-counter in the lab datapath.
//
// PARAMETERS
//  DIGITS  2  number of BCD digits (q width = 4*DIGITS); legal range 1..4
//  WRAP    0  0: stop at zero and enter DONE; 1: after zero, wrap to all-9s and keep running
//
// PORTS
//  clk   in   1         rising-edge clock
//  r     in   1         reset, asynchronous, active-high
//  x     in   1         count enable; one decrement per clk edge while high in RUN
//  ld    in   1         synchronous load strobe
//  d     in   4*DIGITS  BCD load value; nibble i is digit i, nibble 0 is the LSD
//  q     out  4*DIGITS  current count, BCD, registered
//  zero  out  1         q == 0 (combinational from q)
//  bo    out  1         borrow/terminal pulse: high for exactly one cycle when q becomes 0 by decrement
//  busy  out  1         high while state == RUN
//  err   out  1         sticky invalid-load flag
//
// BEHAVIOUR
//  - Reset (r=1, async, wins over everything): q=0, state=IDLE, zero=1, bo=0, busy=0, err=0.
//    Applies immediately, mid-count included. Counting resumes only after r=0 and a new ld.
//  - States:
//      IDLE: x ignored.
//      RUN:  decrement when x=1.
//      DONE: q held at 0; x ignored.
//    Only ld (or r) leaves IDLE and DONE.
//  - Priority at each edge: r > ld > x.
//    ld and x in the same cycle: load wins, no decrement that cycle.
//  - Load with all nibbles of d <= 9 (1-cycle latency):
//      q <= d, err <= 0, bo <= 0.
//      state <= RUN if d != 0.
//      state <= IDLE if d == 0 (no bo is generated).
//  - Load with any nibble of d > 9:
//      q and state unchanged, err <= 1.
//      err stays set until the next valid load or reset.
//  - Decrement (RUN, x=1, ld=0):
//      digit 0 always takes a borrow-in.
//      A digit with borrow-in that is 0 becomes 9 and borrows into the next digit.
//      Otherwise the digit becomes digit-1 and the borrow stops.
//      Result is valid BCD on every cycle; there is never a binary wrap (0xF).
//  - Terminal:
//      Decrement from q=1 gives q <= 0 and bo <= 1 for one cycle (bo coincides with q==0).
//      WRAP=0: state <= DONE; busy drops in the same cycle that bo rises.
//      WRAP=1: stays in RUN; the next enabled decrement gives q <= all 9s
//      (e.g. 99 for DIGITS=2), with no bo on that step.
//  - x=0 in RUN: q holds, bo=0.
//  - bo is never high for two consecutive cycles.
//  - bo and err are registered outputs; busy is decoded from the registered state.
//
// TESTING
//  1 DIGITS=2: load 0x37, count to 0x30, then pulse r for half a cycle
//    -> q=0x00, zero=1, busy=0 before the next clk edge; x afterwards has no effect.
//  2 load 0x23, hold x=1 for 25 cycles
//    -> q=23,22,21,20,19,...,01,00.
//    -> bo=1 only on the cycle q=00.
//    -> busy 1->0 at 00, q stays 00 for the 2 extra cycles.
//  3 load 0x10, one x cycle -> q=0x09; load 0x00 -> q=00, IDLE, bo stays 0.
//  4 load d=0x3A -> err=1, q unchanged; then load 0x05 -> err=0, q=0x05.
//  5 in RUN at q=0x50, assert ld=1 with d=0x42 and x=1 together -> next q=0x42, not 0x49.
//  6 DIGITS=1, WRAP=1: load 2, x for 3 cycles -> q=1, 0 (bo=1), 9; busy stays 1 throughout.

Source files
------------

// File: rtl/bcd_down_counter_if.sv
// Count-control and status bundle for the BCD down-counter.
// The slave modport is the counter side. The master modport is the controller side.
interface bcd_down_counter_if #(
  parameter int DIGITS = 2
);
  logic                  x;
  logic                  ld;
  logic [4*DIGITS-1:0]   d;
  logic [4*DIGITS-1:0]   q;
  logic                  zero;
  logic                  bo;
  logic                  busy;
  logic                  err;

  modport master (output x, ld, d, input q, zero, bo, busy, err);
  modport slave  (input x, ld, d, output q, zero, bo, busy, err);
endinterface

// File: rtl/bcd_down_counter.sv
// Loadable cascaded BCD down-counter with a one-cycle terminal borrow pulse.
// At terminal count it either stops in DONE or wraps to all nines.
module bcd_down_counter #(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b0
) (
  input  logic                  clk,
  input  logic                  r,
  bcd_down_counter_if.slave     cnt_if
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int W = 4 * DIGITS;

  state_t         state_q, state_d;
  logic [W-1:0]   q_q, q_d;
  logic           bo_q, bo_d;
  logic           err_q, err_d;

  logic [W-1:0]   dec_val;
  logic           borrow;
  logic           d_valid;
  logic           busy;

  // Ripple the borrow from the LSD. A zero digit becomes nine and passes the borrow on.
  always_comb begin
    dec_val = q_q;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (q_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = q_q[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  always_comb begin
    d_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_if.d[4*i +: 4] > 4'd9) d_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q <= IDLE;
      q_q     <= '0;
      bo_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      bo_q    <= bo_d;
      err_q   <= err_d;
    end
  end

  // A load beats a decrement. An invalid load only raises err.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    bo_d    = 1'b0;
    err_d   = err_q;
    if (cnt_if.ld) begin
      if (d_valid) begin
        q_d     = cnt_if.d;
        err_d   = 1'b0;
        state_d = (cnt_if.d == '0) ? IDLE : RUN;
      end else begin
        err_d   = 1'b1;
      end
    end else if (state_q == RUN && cnt_if.x) begin
      q_d = dec_val;
      if (dec_val == '0) begin
        bo_d = 1'b1;
        if (!WRAP) state_d = DONE;
      end
    end
  end

  always_comb begin
    busy = (state_q == RUN);
  end

  assign cnt_if.q    = q_q;
  assign cnt_if.zero = (q_q == '0);
  assign cnt_if.bo   = bo_q;
  assign cnt_if.busy = busy;
  assign cnt_if.err  = err_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench for bcd_down_counter.
// It covers a two-digit stop-at-zero counter and a one-digit wrapping counter.
module tb_bcd_down_counter;

  logic clk;
  logic r;
  int   pass_cnt;
  int   total_cnt;

  bcd_down_counter_if #(.DIGITS(2)) if0 ();
  bcd_down_counter_if #(.DIGITS(1)) if1 ();

  bcd_down_counter #(.DIGITS(2), .WRAP(1'b0)) dut0 (.clk(clk), .r(r), .cnt_if(if0.slave));
  bcd_down_counter #(.DIGITS(1), .WRAP(1'b1)) dut1 (.clk(clk), .r(r), .cnt_if(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] to_bcd(int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic test_reset();
    r = 1'b1;
    #2;
    total_cnt++; if (if0.q !== 8'h00) $display("FAIL reset_q got %h exp 00", if0.q); else pass_cnt++;
    total_cnt++; if ({if0.zero, if0.bo, if0.busy, if0.err} !== 4'b1000)
      $display("FAIL reset_flags got %b exp 1000", {if0.zero, if0.bo, if0.busy, if0.err}); else pass_cnt++;
    total_cnt++; if ({if1.q, if1.zero, if1.busy} !== 6'b0000_10)
      $display("FAIL reset_dut1 got %b exp 000010", {if1.q, if1.zero, if1.busy}); else pass_cnt++;
    #5 r = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    if0.ld = 1'b1; if0.d = 8'h37; if0.x = 1'b0;
    tick();
    total_cnt++; if ({if0.q, if0.busy} !== {8'h37, 1'b1})
      $display("FAIL ar_load got %h/%b exp 37/1", if0.q, if0.busy); else pass_cnt++;
    if0.ld = 1'b0; if0.x = 1'b1;
    repeat (7) tick();
    total_cnt++; if (if0.q !== 8'h30) $display("FAIL ar_count got %h exp 30", if0.q); else pass_cnt++;
    @(negedge clk);
    #1 r = 1'b1;
    #1;
    total_cnt++; if ({if0.q, if0.zero, if0.busy} !== {8'h00, 1'b1, 1'b0})
      $display("FAIL ar_async got %h/%b/%b exp 00/1/0", if0.q, if0.zero, if0.busy); else pass_cnt++;
    #1 r = 1'b0;
    repeat (3) tick();
    total_cnt++; if ({if0.q, if0.busy, if0.bo} !== {8'h00, 1'b0, 1'b0})
      $display("FAIL ar_after got %h/%b/%b exp 00/0/0", if0.q, if0.busy, if0.bo); else pass_cnt++;
    if0.x = 1'b0;
  endtask

  task automatic test_countdown();
    int expv;
    if0.ld = 1'b1; if0.d = 8'h23; if0.x = 1'b1;
    tick();
    total_cnt++; if (if0.q !== 8'h23) $display("FAIL cd_load got %h exp 23", if0.q); else pass_cnt++;
    if0.ld = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      expv = (23 - k > 0) ? 23 - k : 0;
      total_cnt++;
      if ({if0.q, if0.bo, if0.busy, if0.zero} !== {to_bcd(expv), k == 23, k < 23, expv == 0})
        $display("FAIL cd_step%0d got %h/%b/%b/%b exp %h/%b/%b/%b", k, if0.q, if0.bo, if0.busy,
                 if0.zero, to_bcd(expv), k == 23, k < 23, expv == 0);
      else pass_cnt++;
    end
    if0.x = 1'b0;
  endtask

  task automatic test_digit_borrow_and_zero_load();
    if0.ld = 1'b1; if0.d = 8'h10;
    tick();
    if0.ld = 1'b0; if0.x = 1'b1;
    tick();
    total_cnt++; if (if0.q !== 8'h09) $display("FAIL bw_q got %h exp 09", if0.q); else pass_cnt++;
    if0.ld = 1'b1; if0.d = 8'h00; if0.x = 1'b0;
    tick();
    total_cnt++; if ({if0.q, if0.busy, if0.bo} !== {8'h00, 1'b0, 1'b0})
      $display("FAIL zl_load got %h/%b/%b exp 00/0/0", if0.q, if0.busy, if0.bo); else pass_cnt++;
    if0.ld = 1'b0; if0.x = 1'b1;
    tick();
    total_cnt++; if ({if0.q, if0.busy, if0.bo} !== {8'h00, 1'b0, 1'b0})
      $display("FAIL zl_idle got %h/%b/%b exp 00/0/0", if0.q, if0.busy, if0.bo); else pass_cnt++;
    if0.x = 1'b0;
  endtask

  task automatic test_invalid_load();
    if0.ld = 1'b1; if0.d = 8'h12;
    tick();
    if0.d = 8'h3A;
    tick();
    total_cnt++; if ({if0.q, if0.err, if0.busy} !== {8'h12, 1'b1, 1'b1})
      $display("FAIL inv_load got %h/%b/%b exp 12/1/1", if0.q, if0.err, if0.busy); else pass_cnt++;
    if0.ld = 1'b0; if0.x = 1'b1;
    tick();
    total_cnt++; if ({if0.q, if0.err} !== {8'h11, 1'b1})
      $display("FAIL inv_sticky got %h/%b exp 11/1", if0.q, if0.err); else pass_cnt++;
    if0.ld = 1'b1; if0.d = 8'h05; if0.x = 1'b0;
    tick();
    total_cnt++; if ({if0.q, if0.err} !== {8'h05, 1'b0})
      $display("FAIL inv_clear got %h/%b exp 05/0", if0.q, if0.err); else pass_cnt++;
    if0.ld = 1'b0;
  endtask

  task automatic test_load_priority();
    if0.ld = 1'b1; if0.d = 8'h50; if0.x = 1'b0;
    tick();
    if0.d = 8'h42; if0.x = 1'b1;
    tick();
    total_cnt++; if (if0.q !== 8'h42) $display("FAIL pri_q got %h exp 42", if0.q); else pass_cnt++;
    if0.ld = 1'b0;
    tick();
    total_cnt++; if (if0.q !== 8'h41) $display("FAIL pri_next got %h exp 41", if0.q); else pass_cnt++;
    if0.x = 1'b0;
  endtask

  task automatic test_wrap();
    logic [3:0] exp_q  [4] = '{4'd1, 4'd0, 4'd9, 4'd8};
    logic       exp_bo [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    if1.ld = 1'b1; if1.d = 4'd2; if1.x = 1'b0;
    tick();
    total_cnt++; if ({if1.q, if1.busy} !== {4'd2, 1'b1})
      $display("FAIL wr_load got %h/%b exp 2/1", if1.q, if1.busy); else pass_cnt++;
    if1.ld = 1'b0; if1.x = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total_cnt++;
      if ({if1.q, if1.bo, if1.busy} !== {exp_q[k], exp_bo[k], 1'b1})
        $display("FAIL wr_step%0d got %h/%b/%b exp %h/%b/1", k, if1.q, if1.bo, if1.busy,
                 exp_q[k], exp_bo[k]);
      else pass_cnt++;
    end
    if1.x = 1'b0;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    if0.x = 1'b0; if0.ld = 1'b0; if0.d = '0;
    if1.x = 1'b0; if1.ld = 1'b0; if1.d = '0;
    test_reset();
    test_async_reset();
    test_countdown();
    test_digit_borrow_and_zero_load();
    test_invalid_load();
    test_load_priority();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
